// File: rtl/pc.sv
// Program counter for the 16-bit core.
// Each rising edge the PC does one of three things:
//   - steps to the next instruction;
//   - takes a PC-relative branch (PC + imm);
//   - jumps to the absolute address in rs.
// out comes straight from the PC register, so no input has a combinational path to it.
module pc #(
  parameter int DATA_W       = 16,
  parameter int PC_IMR_SEL_W = 1,
  parameter int PC_INC       = 1,
  parameter int RESET_PC     = 0
) (
  input  logic                    clock,
  input  logic                    n_rst,
  input  logic [DATA_W-1:0]       imm,
  input  logic [DATA_W-1:0]       rs,
  input  logic [PC_IMR_SEL_W-1:0] imr_sel,
  input  logic                    bre,
  output logic [DATA_W-1:0]       out
);

  localparam logic [DATA_W-1:0]       INC_C    = DATA_W'(PC_INC);
  localparam logic [DATA_W-1:0]       RST_PC_C = DATA_W'(RESET_PC);
  localparam logic [PC_IMR_SEL_W-1:0] SEL_RS_C = PC_IMR_SEL_W'(1);

  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_d;
  logic [DATA_W-1:0] addend_s;
  logic [DATA_W-1:0] sum_s;

  // Next-PC selection. A single adder adds either the step or the branch offset.
  // imm is relative to the branching instruction itself, not to PC+1.
  // While bre=0 neither imm nor rs can reach pc_d, so X on them is harmless.
  always_comb begin
    addend_s = INC_C;
    pc_d     = pc_q;
    if (bre) begin
      addend_s = imm;
    end else begin
      addend_s = INC_C;
    end
    sum_s = pc_q + addend_s;
    if (bre && (imr_sel == SEL_RS_C)) begin
      pc_d = rs;
    end else begin
      pc_d = sum_s;
    end
  end

  // PC register. Reset is synchronous and takes priority over every other update.
  always_ff @(posedge clock) begin
    if (!n_rst) begin
      pc_q <= RST_PC_C;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign out = pc_q;

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for the program counter.
// The expected PC is tracked as a plain integer modulo 2^16, using the architectural rules.
module tb_pc;

  logic        clock;
  logic        n_rst;
  logic [15:0] imm;
  logic [15:0] rs;
  logic [0:0]  imr_sel;
  logic        bre;
  logic [15:0] out;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int exp_pc = 0;   // reference PC value, kept within 0..65535

  pc #(
    .DATA_W(16), .PC_IMR_SEL_W(1), .PC_INC(1), .RESET_PC(0)
  ) dut (
    .clock   (clock),
    .n_rst   (n_rst),
    .imm     (imm),
    .rs      (rs),
    .imr_sel (imr_sel),
    .bre     (bre),
    .out     (out)
  );

  // free-running clock: rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // global time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Reference model: what the PC becomes on one rising edge.
  function automatic int model_next(input int cur, input logic rst_v, input logic bre_v,
                                    input logic sel_v, input logic [15:0] imm_v,
                                    input logic [15:0] rs_v);
    int off;
    if (!rst_v) return 0;
    if (!bre_v) return (cur + 1) % 65536;
    if (sel_v) return int'(rs_v);
    off = int'($signed(imm_v));          // -32768..32767
    return (cur + off + 65536) % 65536;
  endfunction

  // Drive one cycle of inputs, let one rising edge happen, then check out against the model.
  task automatic tick(input string tag, input logic rst_v, input logic bre_v, input logic sel_v,
                      input logic [15:0] imm_v, input logic [15:0] rs_v);
    n_rst   = rst_v;
    bre     = bre_v;
    imr_sel = sel_v;
    imm     = imm_v;
    rs      = rs_v;
    @(posedge clock);
    exp_pc = model_next(exp_pc, rst_v, bre_v, sel_v, imm_v, rs_v);
    #1;
    chk(tag, out, 16'(exp_pc));
  endtask

  initial begin
    logic [15:0] hold_v;
    n_rst = 1'b0; bre = 1'b0; imr_sel = 1'b0; imm = 16'h0000; rs = 16'h0000;
    #1;

    // Reset with the branch inputs active: reset must win.
    tick("reset", 1'b0, 1'b1, 1'b1, 16'h1234, 16'hBEEF);
    chk("reset_const", out, 16'h0000);

    // Plain sequential count 1..100.
    for (int i = 0; i < 100; i++) tick("seq", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("seq_100", out, 16'd100);

    // imr_sel=1 and rs=0 must be ignored while bre=0.
    for (int i = 0; i < 100; i++) tick("sel_ignored", 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
    chk("sel_ignored_200", out, 16'd200);

    // X on the operands while bre=0 must not disturb counting.
    tick("x_operands", 1'b1, 1'b0, 1'bx, 16'hxxxx, 16'hxxxx);

    // PC-relative forward: +0x80, then 10 steps.
    tick("rel_fwd", 1'b1, 1'b1, 1'b0, 16'h0080, 16'h0000);
    chk("rel_fwd_const", out, 16'd201 + 16'h0080);
    for (int i = 0; i < 10; i++) tick("rel_fwd_seq", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // PC-relative backward by 16 (imm = 0xFFF0), then a step.
    hold_v = out;
    tick("rel_back", 1'b1, 1'b1, 1'b0, 16'hFFF0, 16'h0000);
    chk("rel_back_const", out, hold_v - 16'd16);
    tick("rel_back_seq", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Register-absolute jump to 0x8000, then count on from there.
    tick("abs_8000", 1'b1, 1'b1, 1'b1, 16'h0000, 16'h8000);
    chk("abs_8000_const", out, 16'h8000);
    for (int i = 0; i < 3; i++) tick("abs_seq", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("abs_seq_const", out, 16'h8003);

    // Jump to 0xFFFF, then wrap to 0x0000.
    tick("abs_ffff", 1'b1, 1'b1, 1'b1, 16'h0000, 16'hFFFF);
    tick("wrap", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("wrap_const", out, 16'h0000);

    // Backward relative branch from 0x0002 wraps below zero.
    tick("pre_wrap_back", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick("pre_wrap_back", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick("rel_wrap_back", 1'b1, 1'b1, 1'b0, 16'hFFF0, 16'h0000);
    chk("rel_wrap_back_const", out, 16'hFFF2);

    // Reset in the middle of operation.
    for (int i = 0; i < 5; i++) tick("pre_reset", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick("mid_reset", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("mid_reset_const", out, 16'h0000);
    for (int i = 0; i < 3; i++) tick("post_reset", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("post_reset_const", out, 16'h0003);

    // A reset pulse between edges must leave out unchanged.
    hold_v = out;
    n_rst = 1'b0;
    #3;
    n_rst = 1'b1;
    #2;
    chk("rst_pulse_no_edge", out, hold_v);
    tick("after_pulse", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("after_pulse_const", out, 16'h0004);

    // Holding a relative branch for 3 cycles from 0x0010 adds imm each cycle.
    tick("held_setup", 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0010);
    tick("held_rel", 1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000);
    chk("held_rel_1", out, 16'h0012);
    tick("held_rel", 1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000);
    chk("held_rel_2", out, 16'h0014);
    tick("held_rel", 1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000);
    chk("held_rel_3", out, 16'h0016);

    // Holding an absolute jump reloads rs on every cycle.
    tick("held_abs", 1'b1, 1'b1, 1'b1, 16'h0000, 16'h4321);
    tick("held_abs", 1'b1, 1'b1, 1'b1, 16'h0000, 16'h4321);
    chk("held_abs_const", out, 16'h4321);

    // Randomized traffic checked against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic       r_rst;
      logic       r_bre;
      logic       r_sel;
      logic [15:0] r_imm;
      logic [15:0] r_rs;
      r_rst = ($urandom_range(0, 15) != 0);
      r_bre = ($urandom_range(0, 2) == 0);
      r_sel = 1'($urandom_range(0, 1));
      r_imm = 16'($urandom);
      r_rs  = 16'($urandom);
      tick("random", r_rst, r_bre, r_sel, r_imm, r_rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc.md
Name: pc

Overview:
- Program counter for the 16-bit core; holds the address of the current instruction fetch.
- Each clock it does one of three things:
  - increment sequentially;
  - take a PC-relative branch (current PC + immediate);
  - take a register-absolute jump (PC = rs).
- Sits between the decode/branch-resolution logic, which drives bre/imr_sel/imm/rs, and the instruction memory address port, which is driven by out.

Parameters:
- DATA_W, 16, width of PC, immediate and register operand (project-wide data width).
- PC_IMR_SEL_W, 1, width of the branch-target source select.
- PC_INC, 1, sequential increment step (word-addressed instruction memory).
- RESET_PC, 0, value loaded on reset.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- n_rst  in  1  reset, synchronous, active-low; sampled on the rising edge of clock.
- imm  in  DATA_W  signed two's-complement branch offset for PC-relative branches.
- rs  in  DATA_W  register value used as the absolute jump target.
- imr_sel  in  PC_IMR_SEL_W  target source select: 0 = PC-relative (imm), 1 = register absolute (rs).
- bre  in  1  branch enable: 1 = load branch target this cycle, 0 = sequential increment.
- out  out  DATA_W  current program counter value, registered.

Behaviour:
- Reset
  - out is driven by a single DATA_W register.
  - On a rising edge with n_rst=0: out <= RESET_PC (0x0000), regardless of bre/imr_sel/imm/rs.
  - Reset has priority over all other operations.
  - Reset is synchronous: asserting n_rst between edges does not change out until the next rising edge.
  - Reset mid-sequence (after branches or increments) returns out to 0x0000 on that edge.
  - Counting resumes on the first edge with n_rst=1.
- Sequential (n_rst=1, bre=0)
  - out <= out + PC_INC, modulo 2^DATA_W.
  - imr_sel, imm and rs are ignored.
  - Wrap-around: 0xFFFF -> 0x0000, no flag.
- PC-relative (n_rst=1, bre=1, imr_sel=0)
  - out <= out + imm, modulo 2^DATA_W.
  - imm is a signed offset from the current PC value (the address of the branching instruction), not from PC+1.
  - Negative imm (e.g. 0xFFF0 = -16) moves the PC backward; wrap-around is silent in both directions.
- Register absolute (n_rst=1, bre=1, imr_sel=1)
  - out <= rs, verbatim; any 16-bit value is legal, including 0xFFFF.
- Timing
  - Single-cycle latency: the new value is visible on out immediately after the edge where the branch is sampled.
  - The following cycle with bre=0 increments from the branch target.
  - bre is level-sensitive, no handshake: holding bre=1 for N cycles applies the branch N times (relative: accumulates imm each cycle; absolute: reloads rs each cycle).
- Unknown inputs
  - X on imr_sel/imm/rs while bre=0 or n_rst=0 must not affect out.
- Implementation shape
  - One adder computing out + (bre ? imm : PC_INC).
  - A 2:1 mux selecting that sum or rs.
  - The registered out.
  - No combinational path from inputs to out.

Test Plan:
- Reset, then sequential count: n_rst=0 for one edge, then n_rst=1, bre=0, imr_sel=0 for 100 cycles -> out = 0x0000 after reset, then 1,2,...,100.
- imr_sel ignored when bre=0: continue with imr_sel=1, bre=0, rs=0x0000 for 100 cycles -> out keeps incrementing (101..200); rs never loaded.
- PC-relative forward and backward:
  - With out=P, imm=0x0080, bre=1, imr_sel=0 for one cycle -> out=P+0x80; then bre=0 for 10 cycles -> P+0x80+10.
  - Then imm=0xFFF0, bre=1 for one cycle -> out decreases by 16.
  - Then bre=0 -> increments.
- Register absolute: rs=0x8000, imr_sel=1, bre=1 for one cycle -> out=0x8000, then 0x8001.. with bre=0; rs=0xFFFF, bre=1 -> out=0xFFFF, next cycle with bre=0 -> 0x0000 (wrap).
- Reset mid-operation: with out non-zero, n_rst=0 for one edge -> out=0x0000 on that edge; n_rst pulse between edges with no edge while low -> out unchanged; n_rst=1 -> 1,2,3...
- Held branch: bre=1, imr_sel=0, imm=0x0002 for 3 cycles from out=0x0010 -> 0x0012, 0x0014, 0x0016.
